// File: rtl/multiplier.sv
// Sequential shift-add unsigned multiplier, N x N -> 2N bits, one partial product per clock.
// Optional macro MULTIPLIER_EARLY_EXIT_EN ends the operation as soon as no set bits of B remain.
module multiplier #(
    parameter int N = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [N-1:0]     i_multiplicand,
    input  logic [N-1:0]     i_multiplier,
    output logic             o_busy,
    output logic             o_finished,
    output logic [2*N-1:0]   o_product,
    output logic             o_overflow
);

    // Counter is wide enough to hold N itself, so the step index never aliases.
    localparam int CNT_W = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic [2*N-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]     addend;
    logic               last_step;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        addend    = '0;
        last_step = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    a_d     = i_multiplicand;
                    b_d     = i_multiplier;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // B is consumed LSB-first; A is weighted by the step index.
                if (b_q[0]) begin
                    addend = {{N{1'b0}}, a_q} << cnt_q;
                end
                acc_d = acc_q + addend;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
`ifdef MULTIPLIER_EARLY_EXIT_EN
                last_step = (cnt_q == CNT_W'(N - 1)) || (b_d == '0);
`else
                last_step = (cnt_q == CNT_W'(N - 1));
`endif
                if (last_step) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_busy     = (state_q == BUSY);
    assign o_finished = (state_q == DONE);
    // Product is exposed only once complete; zero otherwise so reset/idle read as 0.
    assign o_product  = o_finished ? acc_q : '0;
    assign o_overflow = |o_product[2*N-1:N];

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 Parameter N, default 4: operand width in bits, N >= 2.
REQ-002 i_clock  input  1  sole clock; all state updates on rising edge.
REQ-003 i_reset  input  1  asynchronous, active-low reset.
REQ-004 i_start  input  1  request; sampled on rising edge.
REQ-005 i_multiplicand  input  N  unsigned operand A.
REQ-006 i_multiplier  input  N  unsigned operand B.
REQ-007 o_busy  output  1  high while a multiplication is in progress.
REQ-008 o_finished  output  1  high while o_product holds a completed result.
REQ-009 o_product  output  2N  unsigned A*B.
REQ-010 o_overflow  output  1  high when the result does not fit in N bits.

Function
REQ-011 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-012 In IDLE or DONE, i_start=1 on an edge SHALL do the following on that edge: latch A and B, clear the accumulator and step counter, and enter BUSY.
REQ-013 In BUSY, i_start and operand inputs SHALL be ignored; operands are used only as latched.
REQ-014 Each BUSY edge SHALL perform one shift-add step:
- If the remaining-B LSB is 1, the accumulator adds A shifted left by the step count.
- Remaining B shifts right by 1.
- The counter increments.
REQ-015 After the Nth BUSY step, the FSM SHALL enter DONE; latency from the i_start edge to o_finished high is N edges.
REQ-016 The accumulator SHALL be 2N bits wide and SHALL never wrap; the full product of (2^N-1)^2 is representable.
REQ-017 In DONE, the outputs SHALL be as follows:
- o_finished=1, o_busy=0.
- o_product is the final accumulator value.
- o_overflow = OR of o_product[2N-1:N].
REQ-018 DONE SHALL hold indefinitely until i_start=1, which starts a new operation per REQ-012 and drops o_finished on that edge.
REQ-019 o_busy SHALL be 1 exactly in BUSY; o_busy and o_finished SHALL never both be 1.
REQ-020 o_product and o_overflow are valid only while o_finished=1; while BUSY their values are unspecified.
REQ-021 Operand zero (A=0 or B=0) SHALL complete normally with o_product=0 and o_overflow=0.

Reset
REQ-022 i_reset=0 SHALL immediately, without a clock, force IDLE with o_busy=0, o_finished=0, o_product=0, o_overflow=0, and the counter, accumulator and latched operands cleared.
REQ-023 Reset asserted mid-BUSY SHALL abort the operation; no o_finished pulse is produced for it.
REQ-024 On the first edge after reset deasserts, i_start=1 SHALL be honoured.

Configuration
REQ-025 Macro MULTIPLIER_EARLY_EXIT_EN SHALL control early termination.
REQ-026 With MULTIPLIER_EARLY_EXIT_EN defined:
- A BUSY step whose post-shift remaining B is 0 SHALL transition to DONE on that same edge.
- Latency = max(1, position of highest set bit of B + 1) edges.
- B=0 takes 1 edge.
REQ-027 Without the macro, latency SHALL always be exactly N edges, regardless of operands.
REQ-028 Results (o_product, o_overflow) SHALL be identical in both configurations.

Verification (N=4)
REQ-029 Reset, then A=13, B=11, pulse i_start -> o_finished high 4 edges later, o_product=8'h8F, o_overflow=1.
REQ-030 A=3, B=5 -> o_product=8'h0F, o_overflow=0; latency 4 edges without the macro, 3 edges with MULTIPLIER_EARLY_EXIT_EN.
REQ-031 A=15, B=0 -> o_product=0, o_overflow=0; latency 4 edges, or 1 edge with the macro.
REQ-032 A=15, B=15; change operands to 2,2 and pulse i_start on edge 2 of BUSY -> the second start is ignored, o_product=8'hE1, o_finished held.
REQ-033 Start A=9, B=9; assert i_reset=0 on edge 2 of BUSY -> all outputs 0 immediately; o_finished never rises; a fresh start A=2, B=7 yields 8'h0E.
REQ-034 Back-to-back: from DONE, i_start with A=4, B=4 -> o_finished drops on that edge and rises 4 edges later with o_product=8'h10, o_overflow=1.
